// File: rtl/npc_bp.sv
`default_nettype none
// ============================================================================
// Module   : npc_bp
// Brief    : Fetch PC register with direct-mapped BTB / 2-bit counter
//            prediction and execute-side mispredict redirect.
// Revision : 1.0
// ============================================================================
module npc_bp #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int          BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_pc_sel,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_base_adr,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic [XLEN-1:0] ex_pc4,
    output logic            flush,
    output logic [31:0]     mispredict_cnt
);

    localparam int        c_IDX  = $clog2(BTB_DEPTH);
    localparam int        c_TAGW = XLEN - c_IDX - 2;
    localparam logic [1:0] c_SEL_SEQ  = 2'b00;
    localparam logic [1:0] c_SEL_JAL  = 2'b01;
    localparam logic [1:0] c_SEL_JALR = 2'b10;
    localparam logic [1:0] c_SEL_BR   = 2'b11;

    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_cnt;
    logic              r_valid  [BTB_DEPTH];
    logic [c_TAGW-1:0] r_tag    [BTB_DEPTH];
    logic [XLEN-1:0]   r_target [BTB_DEPTH];
    logic [1:0]        r_ctr    [BTB_DEPTH];

    // Fetch-side lookup
    logic [c_IDX-1:0]  w_idx;
    logic [c_TAGW-1:0] w_tag;
    logic              w_hit;

    assign w_idx       = r_pc[c_IDX+1:2];
    assign w_tag       = r_pc[XLEN-1:c_IDX+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign pred_taken  = w_hit && r_ctr[w_idx][1];
    assign pred_target = w_hit ? r_target[w_idx] : '0;

    // Execute-side resolution
    logic [XLEN-1:0]   w_br_tgt;
    logic [XLEN-1:0]   w_jalr_sum;
    logic [XLEN-1:0]   w_target;
    logic              w_taken;
    logic              w_mispredict;
    logic [c_IDX-1:0]  w_ex_idx;
    logic [c_TAGW-1:0] w_ex_tag;
    logic              w_ex_hit;

    assign ex_pc4     = ex_pc + XLEN'(4);
    assign w_br_tgt   = ex_pc + ex_imm;
    assign w_jalr_sum = ex_base_adr + ex_imm;
    assign w_target   = (ex_pc_sel == c_SEL_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_tgt;
    assign w_taken    = (ex_pc_sel == c_SEL_JAL) || (ex_pc_sel == c_SEL_JALR) ||
                        ((ex_pc_sel == c_SEL_BR) && ex_jump);

    assign w_mispredict = ex_valid && !rst &&
                          ((w_taken != ex_pred_taken) ||
                           (w_taken && (w_target != ex_pred_target)));
    assign flush          = w_mispredict;
    assign mispredict_cnt = r_cnt;
    assign pc             = r_pc;

    assign w_ex_idx = ex_pc[c_IDX+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:c_IDX+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC[XLEN-1:0];
            r_cnt <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else begin
            // Redirect takes priority over backpressure
            if (w_mispredict) begin
                r_pc  <= w_taken ? w_target : ex_pc4;
                r_cnt <= r_cnt + 32'd1;
            end else if (!stall) begin
                r_pc <= pred_taken ? pred_target : r_pc + XLEN'(4);
            end

            if (ex_valid && (ex_pc_sel != c_SEL_SEQ)) begin
                if (ex_pc_sel != c_SEL_BR) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_target;
                    r_ctr[w_ex_idx]    <= 2'b11;
                end else if (w_ex_hit) begin
                    if (ex_jump) begin
                        r_target[w_ex_idx] <= w_target;
                        if (r_ctr[w_ex_idx] != 2'b11)
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else if (ex_jump) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_target;
                    r_ctr[w_ex_idx]    <= 2'b10;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_npc_bp.sv
`default_nettype none
// ============================================================================
// Module   : tb_npc_bp
// Brief    : Directed self-checking bench for npc_bp.
// Revision : 1.0
// ============================================================================
module tb_npc_bp;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_pc_sel;
    logic        ex_jump;
    logic [31:0] ex_imm;
    logic [31:0] ex_base_adr;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] ex_pc4;
    logic        flush;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    npc_bp #(
        .XLEN      (32),
        .RESET_PC  (32'h8000_0000),
        .BTB_DEPTH (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_pc_sel      (ex_pc_sel),
        .ex_jump        (ex_jump),
        .ex_imm         (ex_imm),
        .ex_base_adr    (ex_base_adr),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .ex_pc4         (ex_pc4),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ex_drive(input logic [1:0] sel, input logic [31:0] epc, input logic [31:0] imm,
                            input logic [31:0] base, input logic jump, input logic pt,
                            input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc_sel      = sel;
        ex_pc          = epc;
        ex_imm         = imm;
        ex_base_adr    = base;
        ex_jump        = jump;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic ex_clear();
        ex_valid       = 1'b0;
        ex_pc_sel      = 2'b00;
        ex_pc          = '0;
        ex_imm         = '0;
        ex_base_adr    = '0;
        ex_jump        = 1'b0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        ex_clear();
        tick();
        tick();
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_cnt", mispredict_cnt, 32'd0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        ex_drive(2'b01, 32'h8000_0040, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("rst_ex_ignored", pc, 32'h8000_0000);

        // Free-running sequential fetch
        rst = 1'b0;
        ex_clear();
        #1;
        chk("seq0", pc, 32'h8000_0000);
        tick(); chk("seq1", pc, 32'h8000_0004);
        tick(); chk("seq2", pc, 32'h8000_0008);
        tick(); chk("seq3", pc, 32'h8000_000C);
        chk("seq_pred", {31'd0, pred_taken}, 32'd0);

        // Taken branch learning
        ex_drive(2'b11, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("learn_flush", {31'd0, flush}, 32'd1);
        chk("learn_pc4", ex_pc4, 32'h8000_0014);
        tick();
        ex_clear();
        chk("learn_redirect", pc, 32'h8000_0000);
        chk("learn_cnt", mispredict_cnt, 32'd1);
        repeat (4) tick();
        chk("learn_pc", pc, 32'h8000_0010);
        chk("learn_pred", {31'd0, pred_taken}, 32'd1);
        chk("learn_tgt", pred_target, 32'h8000_0000);
        tick();
        chk("learn_follow", pc, 32'h8000_0000);

        // Hysteresis: 10 -> not taken -> 01
        ex_drive(2'b11, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);
        #1;
        chk("hy_nt_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("hy_nt_pc", pc, 32'h8000_0014);
        chk("hy_nt_cnt", mispredict_cnt, 32'd2);
        ex_drive(2'b00, 32'h8000_000C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0010);
        tick();
        ex_clear();
        chk("stale_pc", pc, 32'h8000_0010);
        chk("stale_cnt", mispredict_cnt, 32'd3);
        chk("hy_01_pred", {31'd0, pred_taken}, 32'd0);
        ex_drive(2'b11, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk("hy_t1_flush", {31'd0, flush}, 32'd1);
        chk("hy_preupdate", {31'd0, pred_taken}, 32'd0);
        tick();
        chk("hy_t1_pc", pc, 32'h8000_0000);
        chk("hy_t1_cnt", mispredict_cnt, 32'd4);
        ex_drive(2'b11, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b1, 32'h8000_0000);
        #1;
        chk("hy_t2_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("hy_t2_pc", pc, 32'h8000_0004);
        chk("hy_t2_cnt", mispredict_cnt, 32'd4);
        // Saturated at 11: one not-taken still leaves it predicting taken
        ex_drive(2'b11, 32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);
        tick();
        chk("hy_sat_pc", pc, 32'h8000_0014);
        ex_drive(2'b00, 32'h8000_000C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0010);
        tick();
        ex_clear();
        chk("hy_sat_at", pc, 32'h8000_0010);
        chk("hy_sat_pred", {31'd0, pred_taken}, 32'd1);
        chk("hy_sat_cnt", mispredict_cnt, 32'd6);

        // jalr alignment
        ex_drive(2'b10, 32'h8000_0020, 32'h2, 32'h8000_1001, 1'b0, 1'b0, 32'h0);
        #1;
        chk("jalr_flush", {31'd0, flush}, 32'd1);
        tick();
        chk("jalr_pc", pc, 32'h8000_1002);
        chk("jalr_cnt", mispredict_cnt, 32'd7);
        ex_drive(2'b00, 32'h8000_001C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_1002);
        tick();
        ex_clear();
        chk("jalr_at", pc, 32'h8000_0020);
        chk("jalr_pred", {31'd0, pred_taken}, 32'd1);
        chk("jalr_tgt", pred_target, 32'h8000_1002);

        // Stall hold, then redirect overriding stall
        stall = 1'b1;
        tick(); chk("stall1", pc, 32'h8000_0020);
        tick(); chk("stall2", pc, 32'h8000_0020);
        tick(); chk("stall3", pc, 32'h8000_0020);
        ex_drive(2'b01, 32'h8000_00FC, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        ex_clear();
        chk("stall_redirect", pc, 32'h8000_0100);
        chk("stall_cnt", mispredict_cnt, 32'd9);
        stall = 1'b0;

        // PC wrap
        ex_drive(2'b10, 32'h8000_0104, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();
        ex_clear();
        chk("wrap_at", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc, 32'h0000_0000);
        ex_drive(2'b00, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wrap_pc4", ex_pc4, 32'h0000_0000);
        chk("seq_noflush", {31'd0, flush}, 32'd0);
        ex_clear();

        // Alias eviction: 8000_0040 and 8000_0080 share index 0
        ex_drive(2'b01, 32'h8000_0040, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("alias_a_pc", pc, 32'h8000_0140);
        ex_drive(2'b00, 32'h8000_003C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0040);
        tick();
        ex_clear();
        chk("alias_a_at", pc, 32'h8000_0040);
        chk("alias_a_pred", {31'd0, pred_taken}, 32'd1);
        chk("alias_a_tgt", pred_target, 32'h8000_0140);
        ex_drive(2'b01, 32'h8000_0080, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("alias_preupdate", {31'd0, pred_taken}, 32'd1);
        tick();
        chk("alias_b_pc", pc, 32'h8000_0280);
        ex_drive(2'b00, 32'h8000_003C, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0040);
        tick();
        ex_clear();
        chk("alias_evict_at", pc, 32'h8000_0040);
        chk("alias_evict_pred", {31'd0, pred_taken}, 32'd0);
        chk("alias_evict_tgt", pred_target, 32'h0);
        chk("alias_cnt", mispredict_cnt, 32'd14);

        // Reset mid-operation invalidates the BTB
        rst = 1'b1;
        ex_drive(2'b01, 32'h8000_0010, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        ex_clear();
        chk("mid_rst_pc", pc, 32'h8000_0000);
        chk("mid_rst_cnt", mispredict_cnt, 32'd0);
        repeat (4) tick();
        chk("mid_rst_at", pc, 32'h8000_0010);
        chk("mid_rst_pred", {31'd0, pred_taken}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
